// File: rtl/fm_dac_mux_if.sv
// Bus bundle for the FM DAC multiplex transmitter: frame load side plus serial DAC outputs.
// master = frame source / receiver side, slave = fm_dac_mux.
interface fm_dac_mux_if;
    logic        ce;
    logic        mute;
    logic [53:0] ch_data;
    logic [5:0]  pan_l;
    logic [5:0]  pan_r;
    logic        dac_en;
    logic [7:0]  dac_data;
    logic        load;
    logic        ready;
    logic        fm_clk1;
    logic        fm_sel23;
    logic [8:0]  MOL;
    logic [8:0]  MOR;
    logic [9:0]  MOL_2612;
    logic [9:0]  MOR_2612;
    logic        frame_start;

    modport master (
        output ce, mute, ch_data, pan_l, pan_r, dac_en, dac_data, load,
        input  ready, fm_clk1, fm_sel23, MOL, MOR, MOL_2612, MOR_2612, frame_start
    );

    modport slave (
        input  ce, mute, ch_data, pan_l, pan_r, dac_en, dac_data, load,
        output ready, fm_clk1, fm_sel23, MOL, MOR, MOL_2612, MOR_2612, frame_start
    );
endinterface

// File: rtl/fm_dac_mux.sv
// Serialises six FM channel samples onto MOL/MOR in YM2612 slot order 1,5,3,2,6,4.
// Latency: a loaded frame is committed at the next slot-0 entry; outputs change only on fm_clk1 rise.
// Backpressure: none; ready is advisory and a load while a frame is pending overwrites it.
module fm_dac_mux #(
    parameter int HALF = 3
) (
    input  logic        clk,
    input  logic        reset,
    fm_dac_mux_if.slave bus
);
    localparam int DW = $clog2(HALF);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

    typedef struct packed {
        logic [53:0] ch;
        logic [5:0]  pan_l;
        logic [5:0]  pan_r;
        logic        dac_en;
        logic [7:0]  dac_data;
    } frame_t;

    logic [DW-1:0] div_cnt;
    logic          clk1_q;
    logic [2:0]    slot_q;
    frame_t        act_q;
    frame_t        pend_q;
    logic          pend_vld_q;
    logic          ready_q;
    logic          sel_q;
    logic          fs_q;
    logic [8:0]    mol_q;
    logic [8:0]    mor_q;
    logic [9:0]    mol26_q;
    logic [9:0]    mor26_q;

    logic          tick;
    logic          advance;
    logic [2:0]    slot_nxt;
    logic          commit;
    logic          pend_vld_nxt;
    frame_t        src;
    frame_t        load_dat;
    logic [8:0]    raw;
    logic          pl_b;
    logic          pr_b;
    logic          is_ch6;
    logic [8:0]    s;
    logic [8:0]    l_s;
    logic [8:0]    r_s;

    assign tick     = bus.ce && (div_cnt == DIV_LAST);
    assign advance  = tick && !clk1_q;
    assign slot_nxt = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
    assign commit   = advance && (slot_nxt == 3'd0) && pend_vld_q;

    // A load on the commit edge must not leak into the committing frame, so the
    // commit always takes the registered pending copy and the new load stays pending.
    assign pend_vld_nxt = bus.load ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
    assign src          = commit ? pend_q : act_q;

    assign load_dat.ch       = bus.ch_data;
    assign load_dat.pan_l    = bus.pan_l;
    assign load_dat.pan_r    = bus.pan_r;
    assign load_dat.dac_en   = bus.dac_en;
    assign load_dat.dac_data = bus.dac_data;

    always_comb begin
        raw    = src.ch[35:27];
        pl_b   = src.pan_l[3];
        pr_b   = src.pan_r[3];
        is_ch6 = 1'b0;
        case (slot_nxt)
            3'd0: begin raw = src.ch[8:0];   pl_b = src.pan_l[0]; pr_b = src.pan_r[0]; end
            3'd1: begin raw = src.ch[44:36]; pl_b = src.pan_l[4]; pr_b = src.pan_r[4]; end
            3'd2: begin raw = src.ch[26:18]; pl_b = src.pan_l[2]; pr_b = src.pan_r[2]; end
            3'd3: begin raw = src.ch[17:9];  pl_b = src.pan_l[1]; pr_b = src.pan_r[1]; end
            3'd4: begin
                raw    = src.ch[53:45];
                pl_b   = src.pan_l[5];
                pr_b   = src.pan_r[5];
                is_ch6 = 1'b1;
            end
            default: ;
        endcase
    end

    // DAC sample is unsigned with 0x80 as zero; flipping the MSB makes it signed, then scale x2.
    assign s   = (is_ch6 && src.dac_en) ? {~src.dac_data[7], src.dac_data[6:0], 1'b0} : raw;
    assign l_s = (pl_b && !bus.mute) ? s : 9'd0;
    assign r_s = (pr_b && !bus.mute) ? s : 9'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            clk1_q     <= 1'b0;
            slot_q     <= 3'd5;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            sel_q      <= 1'b0;
            fs_q       <= 1'b0;
            mol_q      <= 9'h100;
            mor_q      <= 9'h100;
            mol26_q    <= '0;
            mor26_q    <= '0;
        end else begin
            fs_q       <= 1'b0;
            pend_vld_q <= pend_vld_nxt;
            ready_q    <= ~pend_vld_nxt;
            if (bus.load) begin
                pend_q <= load_dat;
            end
            if (bus.ce) begin
                if (tick) begin
                    div_cnt <= '0;
                    clk1_q  <= ~clk1_q;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end
            if (advance) begin
                slot_q  <= slot_nxt;
                sel_q   <= (slot_nxt == 3'd5);
                fs_q    <= (slot_nxt == 3'd0);
                mol_q   <= {~l_s[8], l_s[7:0]};
                mor_q   <= {~r_s[8], r_s[7:0]};
                mol26_q <= {l_s[8], l_s};
                mor26_q <= {r_s[8], r_s};
                if (commit) begin
                    act_q <= pend_q;
                end
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.fm_clk1     = clk1_q;
    assign bus.fm_sel23    = sel_q;
    assign bus.frame_start = fs_q;
    assign bus.MOL         = mol_q;
    assign bus.MOR         = mor_q;
    assign bus.MOL_2612    = mol26_q;
    assign bus.MOR_2612    = mor26_q;
endmodule

// File: tb/tb_fm_dac_mux.sv
// Self-checking bench for fm_dac_mux: slot-level scoreboard plus directed timing, load-ordering and reset checks.
module tb_fm_dac_mux;
    localparam int HALF = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fm_dac_mux_if bus ();
    fm_dac_mux #(.HALF(HALF)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [8:0] mol;
        logic [8:0] mor;
        logic [9:0] mol26;
        logic [9:0] mor26;
        logic       sel;
    } slot_exp_t;

    typedef struct {
        int l;
        int r;
    } sum_exp_t;

    slot_exp_t exp_q[$];
    sum_exp_t  sum_q[$];
    int        slot_ch [6] = '{0, 4, 2, 1, 5, 3};
    int        n_tests = 0;
    int        n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [53:0] pack6(input int c1, input int c2, input int c3,
                                          input int c4, input int c5, input int c6);
        return {c6[8:0], c5[8:0], c4[8:0], c3[8:0], c2[8:0], c1[8:0]};
    endfunction

    // Expected receiver view of one frame, in transmit slot order.
    task automatic push_frame(input logic [53:0] cd, input logic [5:0] pl, input logic [5:0] pr,
                              input logic den, input logic [7:0] dd, input logic mu);
        sum_exp_t  se;
        slot_exp_t e;
        int        c;
        logic [8:0] smp, l, r;
        se.l = 0;
        se.r = 0;
        for (int k = 0; k < 6; k++) begin
            c   = slot_ch[k];
            smp = (c == 5 && den) ? {~dd[7], dd[6:0], 1'b0} : cd[9*c +: 9];
            l   = (pl[c] && !mu) ? smp : 9'd0;
            r   = (pr[c] && !mu) ? smp : 9'd0;
            e.mol   = {~l[8], l[7:0]};
            e.mor   = {~r[8], r[7:0]};
            e.mol26 = {l[8], l};
            e.mor26 = {r[8], r};
            e.sel   = (k == 5);
            exp_q.push_back(e);
            se.l = se.l + int'($signed(l));
            se.r = se.r + int'($signed(r));
        end
        sum_q.push_back(se);
    endtask

    // Monitor: a frame is scored only when it begins at a slot-0 rise with expectations queued.
    logic      prev_clk1 = 1'b0;
    bit        m_on = 1'b0;
    int        m_idx = 0;
    int        got_l = 0;
    int        got_r = 0;
    slot_exp_t m_e;
    sum_exp_t  m_s;

    always @(negedge clk) begin
        if (reset) begin
            prev_clk1 = 1'b0;
            m_on      = 1'b0;
        end else begin
            if (bus.fm_clk1 && !prev_clk1) begin
                if (bus.frame_start && !m_on && exp_q.size() >= 6) begin
                    m_on  = 1'b1;
                    m_idx = 0;
                    got_l = 0;
                    got_r = 0;
                end
                if (m_on) begin
                    m_e = exp_q.pop_front();
                    check_eq($sformatf("slot%0d_MOL", m_idx), bus.MOL, m_e.mol);
                    check_eq($sformatf("slot%0d_MOR", m_idx), bus.MOR, m_e.mor);
                    check_eq($sformatf("slot%0d_MOL_2612", m_idx), bus.MOL_2612, m_e.mol26);
                    check_eq($sformatf("slot%0d_MOR_2612", m_idx), bus.MOR_2612, m_e.mor26);
                    check_eq($sformatf("slot%0d_sel23", m_idx), bus.fm_sel23, m_e.sel);
                    got_l = got_l + int'($signed(bus.MOL_2612));
                    got_r = got_r + int'($signed(bus.MOR_2612));
                    m_idx++;
                    if (m_idx == 6) begin
                        m_s  = sum_q.pop_front();
                        check_eq("frame_sum_l", got_l, m_s.l);
                        check_eq("frame_sum_r", got_r, m_s.r);
                        m_on = 1'b0;
                    end
                end
            end
            prev_clk1 = bus.fm_clk1;
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 400);
        if (!bus.frame_start) check_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("sb_drain", exp_q.size(), 32'd0);
    endtask

    task automatic load_frame(input logic [53:0] cd, input logic [5:0] pl, input logic [5:0] pr,
                              input logic den, input logic [7:0] dd);
        bus.ch_data  = cd;
        bus.pan_l    = pl;
        bus.pan_r    = pr;
        bus.dac_en   = den;
        bus.dac_data = dd;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_fm_clk1"}, bus.fm_clk1, 32'd0);
        check_eq({pfx, "_sel23"}, bus.fm_sel23, 32'd0);
        check_eq({pfx, "_frame_start"}, bus.frame_start, 32'd0);
        check_eq({pfx, "_ready"}, bus.ready, 32'd1);
        check_eq({pfx, "_MOL"}, bus.MOL, 32'h100);
        check_eq({pfx, "_MOR"}, bus.MOR, 32'h100);
        check_eq({pfx, "_MOL_2612"}, bus.MOL_2612, 32'd0);
        check_eq({pfx, "_MOR_2612"}, bus.MOR_2612, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [53:0] cd;
        int first_rise, second_rise, sel_first, sel_last, sel_cnt, fs_n, r_n, rises;
        int fs_idx [8];
        int r_idx [8];
        logic prv;

        reset        = 1'b1;
        bus.ce       = 1'b1;
        bus.mute     = 1'b0;
        bus.ch_data  = '0;
        bus.pan_l    = '0;
        bus.pan_r    = '0;
        bus.dac_en   = 1'b0;
        bus.dac_data = 8'h80;
        bus.load     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Divider, first rise and sel23 window relative to reset release.
        reset = 1'b0;
        first_rise = -1; second_rise = -1; sel_first = -1; sel_last = -1; sel_cnt = 0; fs_n = 0;
        prv = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (bus.fm_clk1 && !prv) begin
                if (first_rise < 0) first_rise = n;
                else if (second_rise < 0) second_rise = n;
            end
            prv = bus.fm_clk1;
            if (bus.fm_sel23) begin
                if (sel_first < 0) sel_first = n;
                sel_last = n;
                sel_cnt++;
            end
            if (bus.frame_start) begin
                if (fs_n < 8) fs_idx[fs_n] = n;
                fs_n++;
            end
        end
        check_eq("t1_first_rise", first_rise, 32'd3);
        check_eq("t1_second_rise", second_rise, 32'd9);
        check_eq("t1_sel_first", sel_first, 32'd33);
        check_eq("t1_sel_last", sel_last, 32'd38);
        check_eq("t1_sel_cnt", sel_cnt, 32'd6);
        check_eq("t1_fs_cnt", fs_n, 32'd2);
        if (fs_n == 2) begin
            check_eq("t1_fs0", fs_idx[0], 32'd3);
            check_eq("t1_fs1", fs_idx[1], 32'd39);
        end

        // Single positive and -1 channel, full pan.
        wait_frame(); @(negedge clk);
        cd = pack6(100, 0, 0, 0, -1, 0);
        push_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80, 1'b0);
        load_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80);

        // Split panning.
        wait_frame(); @(negedge clk);
        cd = pack6(10, 10, 10, 10, 10, 10);
        push_frame(cd, 6'h01, 6'h3E, 1'b0, 8'h80, 1'b0);
        load_frame(cd, 6'h01, 6'h3E, 1'b0, 8'h80);

        // Sample range extremes.
        wait_frame(); @(negedge clk);
        cd = pack6(255, -256, 1, -2, 0, 3);
        push_frame(cd, 6'h3F, 6'h00, 1'b0, 8'h80, 1'b0);
        load_frame(cd, 6'h3F, 6'h00, 1'b0, 8'h80);

        // DAC replaces ch6, full scale positive then negative.
        wait_frame(); @(negedge clk);
        cd = pack6(0, 0, 0, 0, 0, 77);
        push_frame(cd, 6'h3F, 6'h3F, 1'b1, 8'hFF, 1'b0);
        load_frame(cd, 6'h3F, 6'h3F, 1'b1, 8'hFF);

        wait_frame(); @(negedge clk);
        cd = pack6(5, 0, 0, 0, 0, -50);
        push_frame(cd, 6'h3F, 6'h20, 1'b1, 8'h00, 1'b0);
        load_frame(cd, 6'h3F, 6'h20, 1'b1, 8'h00);

        // Mute held over a whole frame.
        wait_drain();
        wait_frame(); @(negedge clk);
        bus.mute = 1'b1;
        cd = pack6(40, -40, 41, -41, 42, -42);
        push_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80, 1'b1);
        load_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80);
        wait_frame();
        wait_frame();
        bus.mute = 1'b0;

        // Load ordering: A then B in one frame, C on the commit edge.
        wait_drain();
        wait_frame();
        check_eq("t5_ready_idle", bus.ready, 32'd1);
        @(negedge clk);
        load_frame(pack6(11, 11, 11, 11, 11, 11), 6'h3F, 6'h3F, 1'b0, 8'h80);
        check_eq("t5_ready_after_A", bus.ready, 32'd0);
        repeat (3) @(negedge clk);
        cd = pack6(1, 2, 3, 4, 5, 6);
        push_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80, 1'b0);
        load_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80);
        repeat (29) @(negedge clk);
        cd = pack6(-7, -6, -5, -4, -3, -2);
        push_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80, 1'b0);
        load_frame(cd, 6'h3F, 6'h3F, 1'b0, 8'h80);
        check_eq("t5_commit_fs", bus.frame_start, 32'd1);
        check_eq("t5_ready_C_pending", bus.ready, 32'd0);
        wait_frame();
        check_eq("t5_ready_after_C", bus.ready, 32'd1);

        // ce toggling halves the rate.
        wait_drain();
        wait_frame(); @(negedge clk);
        cd = pack6(20, 30, 40, 50, 60, -70);
        push_frame(cd, 6'h3F, 6'h3F, 1'b1, 8'h90, 1'b0);
        load_frame(cd, 6'h3F, 6'h3F, 1'b1, 8'h90);
        fs_n = 0; r_n = 0;
        prv = bus.fm_clk1;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (bus.fm_clk1 && !prv) begin
                if (r_n < 8) r_idx[r_n] = i;
                r_n++;
            end
            prv = bus.fm_clk1;
            if (bus.frame_start) begin
                if (fs_n < 8) fs_idx[fs_n] = i;
                fs_n++;
            end
            bus.ce = (i % 2) == 1;
        end
        bus.ce = 1'b1;
        check_eq("t6_enough_rises", r_n >= 3, 32'd1);
        if (r_n >= 3) check_eq("t6_clk1_period", r_idx[2] - r_idx[1], 32'd12);
        check_eq("t6_enough_frames", fs_n >= 2, 32'd1);
        if (fs_n >= 2) check_eq("t6_frame_period", fs_idx[1] - fs_idx[0], 32'd72);

        // Reset asserted in slot 3 with a frame pending.
        wait_drain();
        wait_frame();
        rises = 0;
        prv = bus.fm_clk1;
        for (int n = 0; n < 100 && rises < 3; n++) begin
            @(negedge clk);
            if (bus.fm_clk1 && !prv) rises++;
            prv = bus.fm_clk1;
        end
        check_eq("t7_reached_slot3", rises, 32'd3);
        check_eq("t7_slot3_ch2", bus.MOL_2612, 32'd30);
        load_frame(pack6(99, 99, 99, 99, 99, 99), 6'h3F, 6'h3F, 1'b0, 8'h80);
        check_eq("t7_ready_pending", bus.ready, 32'd0);
        #1 reset = 1'b1;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        push_frame('0, 6'h00, 6'h00, 1'b0, 8'h80, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq("t7_no_rise_clk2", bus.fm_clk1, 32'd0);
        @(negedge clk);
        check_eq("t7_rise_clk3", bus.fm_clk1, 32'd1);
        check_eq("t7_restart_fs", bus.frame_start, 32'd1);
        wait_drain();
        check_eq("t7_ready_end", bus.ready, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
